mbox_fifo: RTL and testbench

MBOX_FIFO -- requirements
Module: mbox_fifo

---
 rtl/mbox_fifo.sv | 130 +++++++++++++
 tb/tb_mbox_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mbox_fifo.sv
// Mailbox byte FIFO between the mailbox writer and the WOU packet consumer.
// It has a registered read port, registered status flags and sticky overflow/underflow flags.
module mbox_fifo #(
    parameter int DW           = 8,
    parameter int AW           = 6,
    parameter int AFULL_MARGIN = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] di_i,
    output logic          full_o,
    output logic          afull_o,
    input  logic          rd_i,
    output logic [DW-1:0] do_o,
    output logic          dvld_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW:0]   FULL_CNT   = DEPTH;
    localparam logic [AW:0]   AFULL_CNT  = DEPTH - AFULL_MARGIN;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic [DW-1:0] do_q,     do_d;
    logic          dvld_q,   dvld_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          afull_q,  afull_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    // The registered flags gate acceptance, so the full or empty state decides which side wins.
    assign wr_acc = wr_i & ~full_q;
    assign rd_acc = rd_i & ~empty_q;
    assign mem_we = wr_acc & ~clr_i;

    // NOTE: every output of a combinational block is given a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_d     = do_q;
        dvld_d   = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                do_d     = mem[rd_ptr_q];
                dvld_d   = 1'b1;
            end
            ovf_d = ovf_q | (wr_i & full_q);
            unf_d = unf_q | (rd_i & empty_q);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        afull_d = (count_d >= AFULL_CNT);
    end

    // NOTE: the storage array is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) mem[wr_ptr_q] <= di_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            do_q     <= '0;
            dvld_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            do_q     <= do_d;
            dvld_q   <= dvld_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign full_o  = full_q;
    assign afull_o = afull_q;
    assign empty_o = empty_q;
    assign count_o = count_q;
    assign do_o    = do_q;
    assign dvld_o  = dvld_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: tb/tb_mbox_fifo.sv
// Scoreboard bench for mbox_fifo: the stimulus pushes expected read data into a queue.
// A negedge monitor pops that queue and compares it against each dvld_o pulse.
module tb_mbox_fifo;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [DW-1:0] di  = '0;
    logic          full_o, afull_o, empty_o, dvld_o, ovf_o, unf_o;
    logic [DW-1:0] do_o;
    logic [AW:0]   count_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rd = '0;

    mbox_fifo #(.DW(DW), .AW(AW), .AFULL_MARGIN(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .clr_i    (clr),
        .wr_i     (wr),
        .di_i     (di),
        .full_o   (full_o),
        .afull_o  (afull_o),
        .rd_i     (rd),
        .do_o     (do_o),
        .dvld_o   (dvld_o),
        .empty_o  (empty_o),
        .count_o  (count_o),
        .ovf_o    (ovf_o),
        .unf_o    (unf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_state(input string name, input int cnt, input logic emp,
                               input logic ful, input logic af);
        check({name, "_count"}, 32'(count_o), 32'(cnt));
        check({name, "_empty"}, 32'(empty_o), 32'(emp));
        check({name, "_full"},  32'(full_o),  32'(ful));
        check({name, "_afull"}, 32'(afull_o), 32'(af));
    endtask

    // One clock of stimulus; the reference queue decides acceptance from its own occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        logic          got_rd;
        logic [DW-1:0] rdv;
        got_rd = 1'b0;
        rdv    = '0;
        @(negedge clk);
        wr = w; rd = r; di = d; clr = c;
        if (c) begin
            model.delete();
        end else begin
            logic can_rd, can_wr;
            can_rd = (model.size() > 0);
            can_wr = (model.size() < DEPTH);
            if (r && can_rd) begin
                rdv    = model.pop_front();
                got_rd = 1'b1;
            end
            if (w && can_wr) model.push_back(d);
        end
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
        if (got_rd) begin
            exp_q.push_back(rdv);
            last_rd = rdv;
        end
    endtask

    // Every accepted read must show up exactly one cycle later with the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && (dvld_o || exp_q.size() > 0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dvld", 32'(dvld_o), 32'd0);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("dvld_pulse", 32'(dvld_o), 32'd1);
                check("rd_data", 32'(do_o), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_state("reset", 0, 1'b1, 1'b0, 1'b0);
        check("reset_do", 32'(do_o), 32'd0);
        check("reset_dvld", 32'(dvld_o), 32'd0);
        check("reset_ovf", 32'(ovf_o), 32'd0);
        check("reset_unf", 32'(unf_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill with 0x00..0x3F, tracking the occupancy-derived flags after every write.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            check_state("fill", i + 1, 1'b0, (i + 1) == DEPTH, (i + 1) >= 56);
        end

        // A write at full is rejected: sticky overflow set and count held.
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        check("ovf_set", 32'(ovf_o), 32'd1);
        check_state("ovf", DEPTH, 1'b0, 1'b1, 1'b1);

        // The drain must return 0x00..0x3F; the first byte is the oldest one, not 0xAA.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check_state("drain", DEPTH - 1 - i, (i + 1) == DEPTH, 1'b0, (DEPTH - 1 - i) >= 56);
        end
        check("ovf_sticky", 32'(ovf_o), 32'd1);

        // Simultaneous write and read at empty: only the write is accepted.
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("unf_set", 32'(unf_o), 32'd1);
        check("unf_dvld", 32'(dvld_o), 32'd0);
        check_state("unf", 1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("unf_next_dvld", 32'(dvld_o), 32'd1);
        check("unf_next_do", 32'(do_o), 32'h55);

        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_unf", 32'(unf_o), 32'd0);

        // Steady streaming at occupancy 10 across several pointer wraps.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1, 8'(i), 1'b0);
            check("stream_count", 32'(count_o), 32'd10);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check_state("stream_end", 0, 1'b1, 1'b0, 1'b0);

        // Bring the FIFO to count 20 with overflow set, then clear it while a write is presented.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i * 3), 1'b0);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        for (int i = 0; i < 44; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check("pre_clr_count", 32'(count_o), 32'd20);
        check("pre_clr_ovf", 32'(ovf_o), 32'd1);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        check_state("clr", 0, 1'b1, 1'b0, 1'b0);
        check("clr_ovf2", 32'(ovf_o), 32'd0);
        check("clr_dvld", 32'(dvld_o), 32'd0);
        check("clr_do_held", 32'(do_o), 32'(last_rd));
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("clr_write_discarded", 32'(unf_o), 32'd1);
        check("clr_write_count", 32'(count_o), 32'd0);

        // Reset asserted between edges while a read result is being presented.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        model.delete();
        #1;
        check_state("async_rst", 0, 1'b1, 1'b0, 1'b0);
        check("async_rst_do", 32'(do_o), 32'd0);
        check("async_rst_dvld", 32'(dvld_o), 32'd0);
        check("async_rst_ovf", 32'(ovf_o), 32'd0);
        check("async_rst_unf", 32'(unf_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b1, 1'b0, 8'h78, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_state("final", 0, 1'b1, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
